// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, addresses a zero-latency instruction memory and
// presents registered instructions to decode over a valid/ready handshake.
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        out_valid_q;
  logic [31:0] out_instr_q;
  logic [31:0] out_pc_q;
  logic        fault_q;
  logic [31:0] fetch_count_q;

  logic [31:0] pc_plus4_d;
  logic [31:0] fetch_count_d;
  logic        pc_legal_d;
  logic        target_legal_d;
  logic        load_d;

  function automatic logic is_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && ((addr >> 2) < 32'(MEM_WORDS));
  endfunction

  assign pc_plus4_d     = pc_q + 32'd4;
  assign fetch_count_d  = fetch_count_q + 32'd1;
  assign pc_legal_d     = is_legal(pc_q);
  assign target_legal_d = is_legal(redirect_target);
  assign load_d         = !out_valid_q || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_instr_q   <= 32'd0;
      out_pc_q      <= 32'd0;
      fault_q       <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      case (state_q)
        RUN: begin
          // Redirect outranks loading: a held instruction is flushed even if accepted.
          if (redirect_valid) begin
            out_valid_q <= 1'b0;
            if (target_legal_d) begin
              pc_q <= redirect_target;
            end else begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end
          end else if (load_d) begin
            if (pc_legal_d) begin
              out_instr_q   <= imem_data;
              out_pc_q      <= pc_q;
              out_valid_q   <= 1'b1;
              pc_q          <= pc_plus4_d;
              fetch_count_q <= fetch_count_d;
            end else begin
              state_q     <= FAULT;
              fault_q     <= 1'b1;
              out_valid_q <= 1'b0;
            end
          end
        end
        FAULT: begin
          // Absorbing until reset.
          state_q <= FAULT;
        end
        default: begin
          state_q <= FAULT;
          fault_q <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign fault       = fault_q;
  assign fetch_count = fetch_count_q;

endmodule

`default_nettype wire
